xoro_arbiter: RTL

XORO_ARBITER -- requirements
Module: xoro_arbiter

---
 rtl/xoro_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/xoro_arbiter.sv
// xoro_arbiter: xoroshiro128+ word generator that hands each word to one
// requester. Ports: clk, rst (sync, active-high), req[N_REQ], gnt[N_REQ]
// (one-hot, registered), rnd[64]/rnd_valid, seed_load, seed[128], busy.
// Build macro XORO_ARB_ROUND_ROBIN_EN: round-robin arbitration when
// defined, fixed priority (lowest index wins) otherwise.
module xoro_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WARMUP = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [63:0]      rnd,
  output logic             rnd_valid,
  input  logic             seed_load,
  input  logic [127:0]     seed,
  output logic             busy
);

  typedef enum logic [1:0] {WARM, RUN, SEED} state_t;

  localparam logic [7:0] WU = 8'(WARMUP);

  state_t          state;
  logic [63:0]     s0, s1;
  logic [63:0]     sx, n0, n1, word;
  logic [63:0]     ld0, ld1;
  logic [7:0]      cnt;
  logic [N_REQ-1:0] win;
  logic            any_req;

  // one xoroshiro128+ step and the output word of the current state
  always_comb begin
    sx   = s0 ^ s1;
    n0   = {s0[8:0], s0[63:9]} ^ sx ^ (sx << 14);
    n1   = {sx[27:0], sx[63:28]};
    word = s0 + s1;
  end

  // an all-zero seed would lock the generator at zero forever
  always_comb begin
    if (seed == '0) begin
      ld0 = 64'd1;
      ld1 = 64'd0;
    end else begin
      ld0 = seed[63:0];
      ld1 = seed[127:64];
    end
  end

  assign any_req = |req;

`ifdef XORO_ARB_ROUND_ROBIN_EN
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr, win_idx;
  logic          found;
  int            k;

  // search starts one past the last granted index
  always_comb begin
    win     = '0;
    win_idx = ptr;
    found   = 1'b0;
    k       = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!found && req[k]) begin
        found   = 1'b1;
        win[k]  = 1'b1;
        win_idx = PW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= PW'(N_REQ - 1);
    else if (state == RUN && !seed_load && any_req)
      ptr <= win_idx;
  end
`else
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WARM;
      s0        <= 64'd1;
      s1        <= 64'd0;
      cnt       <= 8'd0;
      gnt       <= '0;
      rnd       <= 64'd0;
      rnd_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      if (seed_load) begin
        state <= SEED;
        s0    <= ld0;
        s1    <= ld1;
        cnt   <= 8'd0;
        busy  <= 1'b1;
      end else begin
        unique case (state)
          SEED: begin
            state <= WARM;
            cnt   <= 8'd0;
            busy  <= 1'b1;
          end
          WARM: begin
            if (cnt == WU) begin
              state <= RUN;
              busy  <= 1'b0;
            end else begin
              s0  <= n0;
              s1  <= n1;
              cnt <= cnt + 8'd1;
            end
          end
          RUN: begin
            if (any_req) begin
              gnt       <= win;
              rnd       <= word;
              rnd_valid <= 1'b1;
              s0        <= n0;
              s1        <= n1;
            end
          end
          default: begin
            state <= WARM;
            busy  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
